// File: rtl/led_fade_driver.sv
// LED fade driver: per-LED 8-bit level ramps toward its on/off target
// once per PWM period, and drives the LED pins from a shared PWM counter.
module led_fade_driver #(
    parameter int CLK_DIV = 16,
    parameter int STEP    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] leds_i,
    input  logic       en_i,
    output logic [7:0] pwm_o,
    output logic       period_o,
    output logic       busy_o
);

    localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
    localparam logic [8:0]  STEP9   = 9'(STEP);

    logic [15:0] presc;
    logic [7:0]  pwm_cnt;
    logic [7:0]  level     [8];
    logic [7:0]  level_nxt [8];
    logic [7:0]  target    [8];
    logic [7:0]  pwm_nxt;
    logic        tick;
    logic        wrap;

    assign tick = (presc == DIV_MAX);
    assign wrap = tick && (pwm_cnt == 8'hFF);

    // Saturating step toward target; 9-bit math catches over/underflow.
    always_comb begin
        logic [8:0] up_sum;
        logic [8:0] dn_diff;
        logic [7:0] up_val;
        logic [7:0] dn_val;
        busy_o  = 1'b0;
        pwm_nxt = 8'h00;
        for (int i = 0; i < 8; i++) begin
            target[i]    = {8{leds_i[i]}};
            level_nxt[i] = level[i];
            up_sum  = {1'b0, level[i]} + STEP9;
            dn_diff = {1'b0, level[i]} - STEP9;
            up_val  = up_sum[8] ? 8'hFF : up_sum[7:0];
            dn_val  = dn_diff[8] ? 8'h00 : dn_diff[7:0];
            unique case (1'b1)
                !en_i: level_nxt[i] = target[i];
                en_i && wrap && (level[i] < target[i]):
                    level_nxt[i] = up_val;
                en_i && wrap && (level[i] > target[i]):
                    level_nxt[i] = dn_val;
                en_i && !(wrap && (level[i] != target[i])):
                    level_nxt[i] = level[i];
            endcase
            if (en_i) begin
                pwm_nxt[i] = (level[i] == 8'hFF) || (level[i] > pwm_cnt);
            end else begin
                pwm_nxt[i] = leds_i[i];
            end
            if (level[i] != target[i]) begin
                busy_o = 1'b1;
            end
        end
    end

    // Prescaler and PWM counter free-run in both modes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc    <= 16'd0;
            pwm_cnt  <= 8'd0;
            pwm_o    <= 8'h00;
            period_o <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                level[i] <= 8'd0;
            end
        end else begin
            presc    <= tick ? 16'd0 : presc + 16'd1;
            pwm_cnt  <= tick ? pwm_cnt + 8'd1 : pwm_cnt;
            pwm_o    <= pwm_nxt;
            period_o <= wrap;
            for (int i = 0; i < 8; i++) begin
                level[i] <= level_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver: CLK_DIV=1 and CLK_DIV=4
// instances, both with STEP=64, sharing clock and stimulus.
module tb_led_fade_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] leds;
    logic       en;
    logic [7:0] pwm1, pwm4;
    logic       per1, per4, busy1, busy4;

    int vectors = 0;
    int miscompares = 0;
    int duty [8];
    int pulses;
    logic [7:0] exp_q [$];
    int         dexp_q [$];
    logic       bexp_q [$];

    led_fade_driver #(.CLK_DIV(1), .STEP(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .leds_i(leds), .en_i(en),
        .pwm_o(pwm1), .period_o(per1), .busy_o(busy1)
    );

    led_fade_driver #(.CLK_DIV(4), .STEP(64)) dut4 (
        .clk(clk), .rst_n(rst_n), .leds_i(leds), .en_i(en),
        .pwm_o(pwm4), .period_o(per4), .busy_o(busy4)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Counts high samples per pwm bit of dut1 over one 256-cycle period.
    task automatic measure();
        pulses = 0;
        for (int b = 0; b < 8; b++) duty[b] = 0;
        repeat (256) begin
            @(negedge clk);
            for (int b = 0; b < 8; b++) duty[b] += int'(pwm1[b]);
            pulses += int'(per1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        leds  = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if (pwm1 !== 8'h00 || pwm4 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_pwm: got %h/%h want 00", pwm1, pwm4);
        end
        vectors++;
        if (per1 !== 1'b0 || per4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_period: got %b/%b want 0", per1, per4);
        end
        vectors++;
        if (busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy0: got %b want 0", busy1);
        end
        leds = 8'h01;
        #1;
        vectors++;
        if (busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy1: got %b want 1", busy1);
        end
    endtask

    task automatic test_fade_up();
        int n;
        logic bexp;
        int dexp;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (per1 !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (per1 !== 1'b1) begin
            miscompares++;
            $display("FAIL first_wrap: period_o %b want 1", per1);
        end
        dexp_q.push_back(64);  bexp_q.push_back(1'b1);
        dexp_q.push_back(128); bexp_q.push_back(1'b1);
        dexp_q.push_back(192); bexp_q.push_back(1'b1);
        dexp_q.push_back(256); bexp_q.push_back(1'b0);
        while (dexp_q.size() > 0) begin
            bexp = bexp_q.pop_front();
            dexp = dexp_q.pop_front();
            vectors++;
            if (busy1 !== bexp) begin
                miscompares++;
                $display("FAIL fade_up_busy: got %b want %b", busy1, bexp);
            end
            measure();
            vectors++;
            if (duty[0] != dexp) begin
                miscompares++;
                $display("FAIL fade_up_duty: got %0d want %0d", duty[0], dexp);
            end
            vectors++;
            if (pulses != 1) begin
                miscompares++;
                $display("FAIL period_pulses: got %0d want 1", pulses);
            end
        end
    endtask

    task automatic test_fade_down();
        int dexp;
        leds = 8'hFF;
        repeat (4) measure();
        vectors++;
        if (busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL full_busy: got %b want 0", busy1);
        end
        leds = 8'h00;
        measure();
        for (int b = 0; b < 8; b++) begin
            vectors++;
            if (duty[b] != 256) begin
                miscompares++;
                $display("FAIL hold_mid_period bit%0d: got %0d want 256", b, duty[b]);
            end
        end
        dexp_q.push_back(191);
        dexp_q.push_back(127);
        dexp_q.push_back(63);
        dexp_q.push_back(0);
        while (dexp_q.size() > 0) begin
            dexp = dexp_q.pop_front();
            measure();
            for (int b = 0; b < 8; b++) begin
                vectors++;
                if (duty[b] != dexp) begin
                    miscompares++;
                    $display("FAIL fade_down bit%0d: got %0d want %0d", b, duty[b], dexp);
                end
            end
        end
        vectors++;
        if (busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL dark_busy: got %b want 0", busy1);
        end
    endtask

    task automatic test_glitch();
        int hi;
        hi = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            hi += int'(pwm1[0]);
            if (i == 50)  leds = 8'h01;
            if (i == 100) leds = 8'h00;
        end
        dexp_q.push_back(0);
        measure();
        vectors++;
        if (hi + duty[0] != dexp_q.pop_front()) begin
            miscompares++;
            $display("FAIL glitch_no_step: got %0d want 0", hi + duty[0]);
        end
        hi = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            hi += int'(pwm1[0]);
            if (i == 250) leds = 8'h01;
        end
        dexp_q.push_back(0);
        dexp_q.push_back(64);
        vectors++;
        if (hi != dexp_q.pop_front()) begin
            miscompares++;
            $display("FAIL late_set_pre: got %0d want 0", hi);
        end
        measure();
        vectors++;
        if (duty[0] != dexp_q.pop_front()) begin
            miscompares++;
            $display("FAIL late_set_step: got %0d want 64", duty[0]);
        end
    endtask

    task automatic test_passthru();
        logic [7:0] v;
        logic [7:0] e;
        int p;
        int bad;
        p = 0;
        en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            leds = v;
            exp_q.push_back(v);
            @(negedge clk);
            e = exp_q.pop_front();
            p += int'(per1);
            vectors++;
            if (pwm1 !== e || pwm4 !== e || busy1 !== 1'b0) begin
                miscompares++;
                $display("FAIL passthru: pwm %h/%h busy %b want %h busy 0",
                         pwm1, pwm4, busy1, e);
            end
        end
        vectors++;
        if (p != 1) begin
            miscompares++;
            $display("FAIL passthru_period: got %0d want 1", p);
        end
        leds = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (pwm1 !== e || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL passthru_a5: got %h busy %b want %h", pwm1, busy1, e);
        end
        en = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(8'hA5);
            @(negedge clk);
            e = exp_q.pop_front();
            if (pwm1 !== e || pwm4 !== e || busy1 !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reenable_no_fade: %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int n1;
        int bad;
        leds = 8'hFF;
        repeat (1500) @(negedge clk);
        vectors++;
        if (busy4 !== 1'b1) begin
            miscompares++;
            $display("FAIL midfade_busy: got %b want 1", busy4);
        end
        rst_n = 1'b0;
        leds  = 8'h00;
        @(negedge clk);
        vectors++;
        if (pwm4 !== 8'h00 || per4 !== 1'b0 || busy4 !== 1'b0 ||
            pwm1 !== 8'h00 || per1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulse: pwm %h per %b busy %b want 0/0/0",
                     pwm4, per4, busy4);
        end
        rst_n = 1'b1;
        leds  = 8'hFF;
        n   = 1;
        n1  = 0;
        bad = 0;
        while (per4 !== 1'b1 && n <= 1100) begin
            if (pwm4 !== 8'h00) bad++;
            if (per1 === 1'b1 && n1 == 0) n1 = n;
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 1025) begin
            miscompares++;
            $display("FAIL first_period_div4: got cycle %0d want 1025", n);
        end
        vectors++;
        if (n1 != 257) begin
            miscompares++;
            $display("FAIL first_period_div1: got cycle %0d want 257", n1);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL restart_from_zero: %0d high cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_fade_up();
        test_fade_down();
        test_glitch();
        test_passthru();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
